// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - instruction field positions, default widths and hazard helpers
package issue_queue_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_FETCH_W = 2;
    localparam int DEF_ISSUE_W = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INST_W  = 32;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [31:0]      inst_word_t;

    function automatic reg_idx_t rs_of(input inst_word_t inst);
        return inst[RS_MSB:RS_LSB];
    endfunction

    function automatic reg_idx_t rt_of(input inst_word_t inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

    // R-type (op == 0) writes rd, everything else writes rt.
    function automatic reg_idx_t dest_of(input inst_word_t inst);
        return (inst[OP_MSB:OP_LSB] == 6'd0) ? inst[RD_MSB:RD_LSB] : inst[RT_MSB:RT_LSB];
    endfunction

    // RAW or WAW between an older and a younger instruction in the same group.
    function automatic logic hazard(input inst_word_t older, input inst_word_t younger);
        reg_idx_t d;
        d = dest_of(older);
        return (d != ZERO_REG) &&
               ((d == rs_of(younger)) || (d == rt_of(younger)) || (d == dest_of(younger)));
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - fetch push and decode issue signals of the issue queue
interface issue_queue_if #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32
);
    logic                           flush;
    logic [FETCH_W-1:0]             in_valid;
    logic [FETCH_W*ADDR_W-1:0]      in_addr;
    logic [FETCH_W*INST_W-1:0]      in_inst;
    logic                           in_ready;
    logic                           issue_stall;
    logic [ISSUE_W-1:0]             out_valid;
    logic [ISSUE_W*ADDR_W-1:0]      out_addr;
    logic [ISSUE_W*INST_W-1:0]      out_inst;
    logic [$clog2(ISSUE_W+1)-1:0]   out_count;

    modport master (
        output flush, in_valid, in_addr, in_inst, issue_stall,
        input  in_ready, out_valid, out_addr, out_inst, out_count
    );

    modport slave (
        input  flush, in_valid, in_addr, in_inst, issue_stall,
        output in_ready, out_valid, out_addr, out_inst, out_count
    );
endinterface

// File: rtl/issue_queue_hazard_check.sv
// rtl/issue_queue_hazard_check.sv - combinational in-order issue prefix mask for ISSUE_W slots
module issue_hazard_check
    import issue_queue_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int CNT_W   = 5
) (
    input  logic [ISSUE_W*INST_W-1:0] inst,
    input  logic [CNT_W-1:0]          count,
    output logic [ISSUE_W-1:0]        valid
);

    logic prev;
    logic ok;

    // A slot issues only if every older slot issues, it holds a real entry,
    // and no older slot in the group conflicts with it.
    always_comb begin
        valid = '0;
        prev  = 1'b1;
        ok    = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            ok = prev && (int'(count) > k);
            for (int j = 0; j < k; j++) begin
                if (hazard(inst[j*INST_W +: 32], inst[k*INST_W +: 32])) begin
                    ok = 1'b0;
                end
            end
            valid[k] = ok;
            prev     = ok;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - fetch-to-decode circular instruction queue; ISSUE_QUEUE_STATS_EN adds issue statistics
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int ISSUE_W = DEF_ISSUE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INST_W  = DEF_INST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    issue_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]                stat_full_issue,
    output logic [31:0]                stat_hazard_split
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int OCNT_W = $clog2(ISSUE_W+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [ISSUE_W*ADDR_W-1:0] win_addr;
    logic [ISSUE_W*INST_W-1:0] win_inst;
    logic [ISSUE_W-1:0]        win_valid;
    logic [OCNT_W-1:0]         win_count;
    logic                      in_ready;
    logic [CNT_W-1:0]          push_n;
    logic [CNT_W-1:0]          pop_n;

    // Oldest ISSUE_W entries, read straight from storage (no push bypass).
    always_comb begin
        win_addr = '0;
        win_inst = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            win_addr[k*ADDR_W +: ADDR_W] = addr_q[head_q + PTR_W'(k)];
            win_inst[k*INST_W +: INST_W] = inst_q[head_q + PTR_W'(k)];
        end
    end

    issue_hazard_check #(
        .ISSUE_W (ISSUE_W),
        .INST_W  (INST_W),
        .CNT_W   (CNT_W)
    ) u_hazard (
        .inst  (win_inst),
        .count (count_q),
        .valid (win_valid)
    );

    always_comb begin
        win_count = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            win_count = win_count + OCNT_W'(win_valid[k]);
        end
    end

    assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));

    always_comb begin
        push_n = '0;
        if (in_ready) begin
            for (int i = 0; i < FETCH_W; i++) begin
                push_n = push_n + CNT_W'(bus.in_valid[i]);
            end
        end
    end

    assign pop_n = bus.issue_stall ? '0 : CNT_W'(win_count);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_n);
            tail_q  <= tail_q + PTR_W'(push_n);
            count_q <= count_q + push_n - pop_n;
        end
    end

    // Storage carries no reset; entries outside head..tail are never observed.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && in_ready) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (bus.in_valid[i]) begin
                    addr_q[tail_q + PTR_W'(i)] <= bus.in_addr[i*ADDR_W +: ADDR_W];
                    inst_q[tail_q + PTR_W'(i)] <= bus.in_inst[i*INST_W +: INST_W];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = win_valid;
    assign bus.out_addr  = win_addr;
    assign bus.out_inst  = win_inst;
    assign bus.out_count = win_count;
    assign count         = count_q;

`ifdef ISSUE_QUEUE_STATS_EN
    logic full_issue;
    logic hazard_split;

    // A present slot right behind a valid prefix can only be held back by a hazard.
    assign full_issue   = !bus.issue_stall && (win_count == OCNT_W'(ISSUE_W));
    assign hazard_split = !bus.issue_stall && (count_q > CNT_W'(win_count)) &&
                          (win_count < OCNT_W'(ISSUE_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_full_issue   <= '0;
            stat_hazard_split <= '0;
        end else begin
            if (full_issue && (stat_full_issue != '1)) begin
                stat_full_issue <= stat_full_issue + 32'd1;
            end
            if (hazard_split && (stat_hazard_split != '1)) begin
                stat_hazard_split <= stat_hazard_split + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue at DEPTH 16 and DEPTH 4
module tb_issue_queue;

    logic clk;
    logic reset;
    logic [4:0] count16;
    logic [2:0] count4;
    int checks;
    int errors;

    issue_queue_if #(.FETCH_W(2), .ISSUE_W(2), .ADDR_W(32), .INST_W(32)) b ();
    issue_queue_if #(.FETCH_W(2), .ISSUE_W(2), .ADDR_W(32), .INST_W(32)) b4 ();

`ifdef ISSUE_QUEUE_STATS_EN
    logic [31:0] sf16, sh16, sf4, sh4;
`endif

    issue_queue #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2), .ADDR_W(32), .INST_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b),
        .count (count16)
`ifdef ISSUE_QUEUE_STATS_EN
        ,
        .stat_full_issue   (sf16),
        .stat_hazard_split (sh16)
`endif
    );

    issue_queue #(.DEPTH(4), .FETCH_W(2), .ISSUE_W(2), .ADDR_W(32), .INST_W(32)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4),
        .count (count4)
`ifdef ISSUE_QUEUE_STATS_EN
        ,
        .stat_full_issue   (sf4),
        .stat_hazard_split (sh4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [31:0] a0, input logic [31:0] i0,
                         input logic [31:0] a1, input logic [31:0] i1);
        b.in_valid = 2'b11;
        b.in_addr  = {a1, a0};
        b.in_inst  = {i1, i0};
    endtask

    task automatic push2_d4(input logic [31:0] a0, input logic [31:0] a1);
        b4.in_valid = 2'b11;
        b4.in_addr  = {a1, a0};
        b4.in_inst  = 64'h0;
    endtask

    logic [31:0] exp_addr;
    int          n_out;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        b.flush = 0;  b.in_valid = 0;  b.in_addr = 0;  b.in_inst = 0;  b.issue_stall = 0;
        b4.flush = 0; b4.in_valid = 0; b4.in_addr = 0; b4.in_inst = 0; b4.issue_stall = 0;
        tick();
        tick();
        reset = 1'b0;

        chk("reset_count", 64'(count16), 64'd0);
        chk("reset_out_valid", 64'(b.out_valid), 64'd0);
        chk("reset_out_count", 64'(b.out_count), 64'd0);
        chk("reset_in_ready", 64'(b.in_ready), 64'd1);

        // Independent pair: dual issue
        push2(32'h1000, 32'h00430820, 32'h1004, 32'h00A62020);
        tick();
        b.in_valid = 0;
        chk("dual_out_valid", 64'(b.out_valid), 64'd3);
        chk("dual_out_count", 64'(b.out_count), 64'd2);
        chk("dual_addr0", 64'(b.out_addr[31:0]), 64'h1000);
        chk("dual_addr1", 64'(b.out_addr[63:32]), 64'h1004);
        chk("dual_inst1", 64'(b.out_inst[63:32]), 64'h00A62020);
        tick();
        chk("dual_drained", 64'(count16), 64'd0);

        // RAW on r1
        push2(32'h1008, 32'h00430820, 32'h100C, 32'h00283821);
        tick();
        b.in_valid = 0;
        chk("raw_out_valid", 64'(b.out_valid), 64'd1);
        chk("raw_count", 64'(count16), 64'd2);
        tick();
        chk("raw_second_valid", 64'(b.out_valid), 64'd1);
        chk("raw_second_addr", 64'(b.out_addr[31:0]), 64'h100C);
        chk("raw_second_inst", 64'(b.out_inst[31:0]), 64'h00283821);
        tick();
        chk("raw_drained", 64'(count16), 64'd0);

        // WAW on r9
        push2(32'h1010, 32'h24090005, 32'h1014, 32'h00434821);
        tick();
        b.in_valid = 0;
        chk("waw_out_valid", 64'(b.out_valid), 64'd1);
        tick();
        tick();
        chk("waw_drained", 64'(count16), 64'd0);

        // dest r0 never creates a hazard
        push2(32'h1018, 32'h24000007, 32'h101C, 32'h00002021);
        tick();
        b.in_valid = 0;
        chk("r0_out_valid", 64'(b.out_valid), 64'd3);
        tick();
        chk("r0_drained", 64'(count16), 64'd0);

        // Fill under stall, wrapping from head 8
        b.issue_stall = 1;
        for (int n = 0; n < 7; n++) begin
            push2(32'h2000 + 32'(8*n), 32'h0, 32'h2004 + 32'(8*n), 32'h0);
            tick();
        end
        chk("fill14_count", 64'(count16), 64'd14);
        chk("fill14_in_ready", 64'(b.in_ready), 64'd1);
        b.in_valid = 2'b01;
        b.in_addr  = {32'h0, 32'h2038};
        tick();
        chk("fill15_count", 64'(count16), 64'd15);
        chk("fill15_in_ready", 64'(b.in_ready), 64'd0);
        push2(32'h203C, 32'h0, 32'h2040, 32'h0);
        tick();
        chk("drop_count", 64'(count16), 64'd15);
        chk("stall_out_addr0", 64'(b.out_addr[31:0]), 64'h2000);
        b.in_valid = 0;
        b.issue_stall = 0;
        exp_addr = 32'h2000;
        for (int cyc = 0; cyc < 20 && count16 != 0; cyc++) begin
            n_out = (count16 >= 2) ? 2 : 1;
            chk("drain_out_count", 64'(b.out_count), 64'(n_out));
            for (int k = 0; k < n_out; k++) begin
                chk("drain_addr", 64'(b.out_addr[k*32 +: 32]), 64'(exp_addr));
                exp_addr = exp_addr + 32'd4;
            end
            tick();
        end
        chk("drain_final_addr", 64'(exp_addr), 64'h203C);
        chk("drain_final_count", 64'(count16), 64'd0);

        // DEPTH=4 wrap: move tail and head to entry 3
        push2_d4(32'h3000, 32'h3004);
        tick();
        b4.in_valid = 0;
        tick();
        b4.in_valid = 2'b01;
        b4.in_addr  = {32'h0, 32'h3008};
        tick();
        b4.in_valid = 0;
        chk("d4_single_addr", 64'(b4.out_addr[31:0]), 64'h3008);
        tick();
        chk("d4_empty", 64'(count4), 64'd0);
        push2_d4(32'h3010, 32'h3014);
        tick();
        b4.in_valid = 0;
        chk("d4_wrap_valid", 64'(b4.out_valid), 64'd3);
        chk("d4_wrap_count", 64'(count4), 64'd2);
        chk("d4_wrap_addr0", 64'(b4.out_addr[31:0]), 64'h3010);
        chk("d4_wrap_addr1", 64'(b4.out_addr[63:32]), 64'h3014);
        tick();
        chk("d4_wrap_drained", 64'(count4), 64'd0);

        // Flush beats a coincident push and pop
        b.issue_stall = 1;
        for (int n = 0; n < 3; n++) begin
            push2(32'h4000 + 32'(8*n), 32'h0, 32'h4004 + 32'(8*n), 32'h0);
            tick();
        end
        chk("preflush_count", 64'(count16), 64'd6);
        b.issue_stall = 0;
        b.flush = 1;
        push2(32'h4100, 32'h0, 32'h4104, 32'h0);
        tick();
        b.flush = 0;
        b.in_valid = 0;
        chk("flush_count", 64'(count16), 64'd0);
        chk("flush_out_valid", 64'(b.out_valid), 64'd0);
        chk("flush_out_count", 64'(b.out_count), 64'd0);
        chk("flush_in_ready", 64'(b.in_ready), 64'd1);
        tick();
        chk("flush_stays_empty", 64'(count16), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
